// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: pipelined Wallace-tree multiplier with per-operation signed/unsigned mode.
// Stage 1 registers the partial products, middle stages share the 3:2 CSA levels,
// and the last stage does the carry-propagate add into the output register.
module wallace_mult_pipe #(
  parameter int WIDTH       = 8,
  parameter int PIPE_STAGES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);
  localparam int PW = 2 * WIDTH;
  localparam int NR = WIDTH + 1;  // WIDTH partial-product rows plus the Baugh-Wooley constant row

  typedef logic [NR-1:0][PW-1:0] rows_t;

  // Row count after one Wallace level: each triple becomes sum+carry, leftovers pass.
  function automatic int next_cnt(int n);
    return (n / 3) * 2 + (n % 3);
  endfunction

  function automatic int cnt_after(int lv);
    int n;
    n = NR;
    for (int i = 0; i < lv; i++) n = next_cnt(n);
    return n;
  endfunction

  function automatic int num_lvls();
    int n;
    int l;
    n = NR;
    l = 0;
    while (n > 2) begin
      n = next_cnt(n);
      l++;
    end
    return l;
  endfunction

  localparam int NLVL = num_lvls();

  // Levels completed by the end of stage s. With fewer than three stages the
  // whole tree sits in stage 1; otherwise the middle stages split it evenly.
  function automatic int lvl_done(int s);
    int m;
    m = (PIPE_STAGES > 2) ? PIPE_STAGES - 2 : 1;
    if (s <= 0) return 0;
    if (s >= PIPE_STAGES - 1) return NLVL;
    return (NLVL * (s - 1) + m - 1) / m;
  endfunction

  // Baugh-Wooley rows: bits pairing exactly one MSB are inverted in signed mode,
  // and the correction constant lives in its own row.
  function automatic rows_t pp_rows(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y, logic sm);
    rows_t r;
    logic [PW-1:0] row;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      row = '0;
      for (int j = 0; j < WIDTH; j++)
        row[i+j] = (x[j] & y[i]) ^ (sm & ((i == WIDTH-1) != (j == WIDTH-1)));
      r[i] = row;
    end
    r[NR-1][WIDTH] = sm;
    r[NR-1][PW-1]  = sm;
    return r;
  endfunction

  // One carry-save level over the first n rows; carries shift up, top carry dropped.
  function automatic rows_t csa_level(rows_t r, int n);
    rows_t o;
    int g;
    o = '0;
    g = n / 3;
    for (int k = 0; k < NR / 3; k++) begin
      if (k < g) begin
        o[2*k]   = r[3*k] ^ r[3*k+1] ^ r[3*k+2];
        o[2*k+1] = ((r[3*k] & r[3*k+1]) | (r[3*k] & r[3*k+2]) | (r[3*k+1] & r[3*k+2])) << 1;
      end
    end
    for (int k = 0; k < 2; k++)
      if (k < n % 3) o[2*g+k] = r[3*g+k];
    return o;
  endfunction

  logic [PIPE_STAGES:1] vld_pipe;
  rows_t                stg_q [1:PIPE_STAGES];
  logic                 stall;

  assign out_valid = vld_pipe[PIPE_STAGES];
  assign p         = stg_q[PIPE_STAGES][0];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

  for (genvar s = 1; s <= PIPE_STAGES; s++) begin : g_stg
    localparam int LO = lvl_done(s - 1);
    localparam int HI = lvl_done(s);
    rows_t d_in;
    rows_t d_nxt;
    logic  v_in;

    if (s == 1) begin : g_first
      assign d_in = pp_rows(a, b, signed_mode);
      assign v_in = in_valid;
    end else begin : g_next
      assign d_in = stg_q[s-1];
      assign v_in = vld_pipe[s-1];
    end

    // This stage's share of CSA levels; the last stage closes with the CPA.
    always_comb begin
      d_nxt = d_in;
      for (int l = LO; l < HI; l++) d_nxt = csa_level(d_nxt, cnt_after(l));
      if (s == PIPE_STAGES) begin
        d_nxt[0] = d_nxt[0] + d_nxt[1];
        for (int k = 1; k < NR; k++) d_nxt[k] = '0;
      end
    end

    // Stage register: whole pipe freezes while the output is stalled.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        stg_q[s]    <= '0;
        vld_pipe[s] <= 1'b0;
      end else if (!stall) begin
        stg_q[s]    <= d_nxt;
        vld_pipe[s] <= v_in;
      end
    end
  end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Directed bench for wallace_mult_pipe: W=4/P=3 main instance plus W=8 at P=1..4.
module tb_wallace_mult_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, in_ready, signed_mode, out_valid, out_ready;
  logic [3:0] a, b;
  logic [7:0] p;

  logic        in_valid8, m8;
  logic [7:0]  a8, b8;
  logic [4:1]  ir8, ov8;
  logic [15:0] p8 [1:4];

  int errors = 0;
  int checks = 0;

  wallace_mult_pipe #(.WIDTH(4), .PIPE_STAGES(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready), .p(p));

  for (genvar g = 1; g <= 4; g++) begin : g_w8
    wallace_mult_pipe #(.WIDTH(8), .PIPE_STAGES(g)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(ir8[g]),
      .a(a8), .b(b8), .signed_mode(m8),
      .out_valid(ov8[g]), .out_ready(1'b1), .p(p8[g]));
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref4(logic [3:0] x, logic [3:0] y, logic m);
    logic signed [7:0] sx, sy;
    sx = m ? {{4{x[3]}}, x} : {4'b0, x};
    sy = m ? {{4{y[3]}}, y} : {4'b0, y};
    return 8'(sx * sy);
  endfunction

  function automatic logic [15:0] ref8(logic [7:0] x, logic [7:0] y, logic m);
    logic signed [15:0] sx, sy;
    sx = m ? {{8{x[7]}}, x} : {8'b0, x};
    sy = m ? {{8{y[7]}}, y} : {8'b0, y};
    return 16'(sx * sy);
  endfunction

  logic [3:0] qa [$];
  logic [3:0] qb [$];
  logic       qm [$];
  logic [7:0] qe [$];

  task automatic push(input logic [3:0] x, input logic [3:0] y, input logic m);
    qa.push_back(x); qb.push_back(y); qm.push_back(m); qe.push_back(ref4(x, y, m));
  endtask

  // Feed the queued ops under valid/ready and check every delivered product in order.
  // hold>0: force out_ready low for that many cycles once out_valid first rises.
  task automatic stream(input string tag, input bit rnd, input int hold);
    int n, sent, got, held, cyc;
    bit seen, prev_stall;
    logic [7:0] hp;
    n = qa.size(); sent = 0; got = 0; held = 0; cyc = 0; seen = 0; prev_stall = 0; hp = '0;
    while (got < n && cyc < 20000) begin
      in_valid = (sent < n);
      if (sent < n) begin a = qa[sent]; b = qb[sent]; signed_mode = qm[sent]; end
      if (out_valid) seen = 1;
      if (hold > 0 && seen && held < hold) begin out_ready = 1'b0; held++; end
      else out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (prev_stall) begin
        chk({tag, " held valid"}, 16'(out_valid), 16'd1);
        chk({tag, " held p"}, 16'(p), 16'(hp));
      end
      prev_stall = out_valid & ~out_ready;
      if (prev_stall) chk({tag, " in_ready stall"}, 16'(in_ready), 16'd0);
      hp = p;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk({tag, " p"}, 16'(p), 16'(qe[got]));
        got++;
      end
      @(posedge clk); #1; cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk({tag, " count"}, 16'(got), 16'(n));
    qa.delete(); qb.delete(); qm.delete(); qe.delete();
  endtask

  bit          ghost;
  int          lat [1:4];
  int          oidx [1:4];
  logic [7:0]  ra [10];
  logic [7:0]  rb [10];
  logic        rm [10];
  logic [15:0] re [10];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; m8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 16'(out_valid), 16'd0);
    chk("reset p", 16'(p), 16'd0);
    chk("reset in_ready", 16'(in_ready), 16'd1);
    rst_n = 1'b1;

    // 15*15 unsigned, valid two edges after accept
    a = 4'hF; b = 4'hF; signed_mode = 1'b0; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("t1 edge N", 16'(out_valid), 16'd0);
    tick(); chk("t1 edge N+1", 16'(out_valid), 16'd0);
    tick(); chk("t1 edge N+2 valid", 16'(out_valid), 16'd1);
    chk("t1 p", 16'(p), 16'h00E1);
    tick(); chk("t1 drained", 16'(out_valid), 16'd0);

    // mixed modes back to back
    a = 4'h8; b = 4'h8; signed_mode = 1'b1; in_valid = 1'b1; tick();
    a = 4'hF; b = 4'h7; signed_mode = 1'b1; tick();
    a = 4'hF; b = 4'h7; signed_mode = 1'b0; tick();
    in_valid = 1'b0;
    chk("t2 v0", 16'(out_valid), 16'd1); chk("t2 -8*-8", 16'(p), 16'h0040);
    tick(); chk("t2 v1", 16'(out_valid), 16'd1); chk("t2 -1*7", 16'(p), 16'h00F9);
    tick(); chk("t2 v2", 16'(out_valid), 16'd1); chk("t2 15*7", 16'(p), 16'h0069);
    tick(); chk("t2 drained", 16'(out_valid), 16'd0);

    // backpressure: 4 stall cycles once the first result shows
    push(4'h3, 4'h5, 1'b0);  // 0x0F
    push(4'hF, 4'hF, 1'b1);  // 0x01
    push(4'h7, 4'h8, 1'b1);  // 0xC8
    push(4'hA, 4'h3, 1'b0);  // 0x1E
    push(4'h9, 4'h6, 1'b1);  // 0xD6
    chk("t3 table", 16'(qe[2]), 16'h00C8);
    stream("t3", 1'b0, 4);

    // reset with ops in flight: nothing may come out afterwards
    a = 4'h1; b = 4'h2; signed_mode = 1'b0; in_valid = 1'b1; tick();
    a = 4'h3; b = 4'h3; tick();
    a = 4'h5; b = 4'h5; rst_n = 1'b0; tick();
    rst_n = 1'b1; in_valid = 1'b0;
    chk("t4 out_valid", 16'(out_valid), 16'd0);
    chk("t4 p", 16'(p), 16'd0);
    chk("t4 in_ready", 16'(in_ready), 16'd1);
    ghost = 1'b0;
    repeat (6) begin tick(); if (out_valid) ghost = 1'b1; end
    chk("t4 no ghost", 16'(ghost), 16'd0);

    // exhaustive 4x4, both modes, random out_ready
    for (int m = 0; m < 2; m++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          push(4'(x), 4'(y), 1'(m));
    stream("t5", 1'b1, 0);

    // WIDTH=8 sweep: latency of PIPE_STAGES-1 edges, -128*-128 corner
    for (int g = 1; g <= 4; g++) begin lat[g] = -1; oidx[g] = 0; end
    a8 = 8'h80; b8 = 8'h80; m8 = 1'b1; in_valid8 = 1'b1;
    tick(); in_valid8 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      for (int g = 1; g <= 4; g++)
        if (ov8[g] && lat[g] < 0) begin
          lat[g] = k;
          chk($sformatf("t6 P%0d corner", g), p8[g], 16'h4000);
        end
      tick();
    end
    for (int g = 1; g <= 4; g++)
      chk($sformatf("t6 P%0d latency", g), 16'(lat[g]), 16'(g - 1));

    for (int i = 0; i < 10; i++) begin
      ra[i] = 8'($urandom); rb[i] = 8'($urandom); rm[i] = 1'($urandom);
      re[i] = ref8(ra[i], rb[i], rm[i]);
    end
    for (int c = 0; c < 16; c++) begin
      for (int g = 1; g <= 4; g++)
        if (ov8[g]) begin
          if (oidx[g] < 10) chk($sformatf("t6 P%0d op%0d", g, oidx[g]), p8[g], re[oidx[g]]);
          oidx[g]++;
        end
      in_valid8 = (c < 10);
      if (c < 10) begin a8 = ra[c]; b8 = rb[c]; m8 = rm[c]; end
      tick();
    end
    for (int g = 1; g <= 4; g++)
      chk($sformatf("t6 P%0d count", g), 16'(oidx[g]), 16'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
